floo_id_remapper: RTL and testbench

FLOO_ID_REMAPPER -- requirements
Module: floo_id_remapper

---
 rtl/floo_id_remapper.sv | 133 +++++++++++++
 tb/tb_floo_id_remapper.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/floo_id_remapper.sv
// Remaps wide request IDs onto a small table of in-flight IDs. Each entry
// tracks one original ID and how many transactions are outstanding on it;
// responses come back on the table index and get their original ID restored.
module floo_id_remapper #(
  parameter int unsigned InIdWidth    = 4,
  parameter int unsigned MaxUniqIds   = 4,
  parameter int unsigned MaxTxnsPerId = 8,
  localparam int unsigned OutIdWidth  = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic [InIdWidth-1:0]  req_id_i,
  output logic                  req_ready_o,
  output logic [OutIdWidth-1:0] req_id_o,
  input  logic                  rsp_pop_i,
  input  logic [OutIdWidth-1:0] rsp_id_i,
  output logic [InIdWidth-1:0]  rsp_id_o,
  output logic                  full_o
);

  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);

  logic [MaxUniqIds-1:0] valid_reg;
  logic [InIdWidth-1:0]  id_reg  [MaxUniqIds];
  logic [CntWidth-1:0]   cnt_reg [MaxUniqIds];

  logic [MaxUniqIds-1:0] match_vec;
  logic [MaxUniqIds-1:0] push_vec;
  logic [MaxUniqIds-1:0] pop_vec;
  logic [MaxUniqIds-1:0] pop_eff;
  logic                  match_any;
  logic [OutIdWidth-1:0] match_idx;
  logic                  free_any;
  logic [OutIdWidth-1:0] free_idx;
  logic                  push;

  assign push = req_valid_i && req_ready_o;

  // Per-entry decode of lookup hit, push target and pop target.
  generate
    for (genvar gi = 0; gi < MaxUniqIds; gi++) begin : g_entry
      assign match_vec[gi] = valid_reg[gi] && (id_reg[gi] == req_id_i);
      assign push_vec[gi]  = push && (req_id_o == OutIdWidth'(gi));
      assign pop_vec[gi]   = rsp_pop_i && (rsp_id_i == OutIdWidth'(gi));
      // A pop to an invalid entry is ignored so the table state stays sane.
      assign pop_eff[gi]   = pop_vec[gi] && valid_reg[gi];
    end
  endgenerate

  // Lowest-index priority search for the matching entry and the first free entry.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = MaxUniqIds - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_any = 1'b1;
        match_idx = OutIdWidth'(i);
      end
      if (!valid_reg[i]) begin
        free_any = 1'b1;
        free_idx = OutIdWidth'(i);
      end
    end
  end

  // Request side: reuse a matching entry if it has room, else allocate a free one.
  // Depends only on registered state and req_id_i, so pops never shorten a request.
  always_comb begin
    req_ready_o = 1'b0;
    req_id_o    = '0;
    if (match_any) begin
      req_id_o    = match_idx;
      req_ready_o = cnt_reg[match_idx] < CntWidth'(MaxTxnsPerId);
    end else if (free_any) begin
      req_id_o    = free_idx;
      req_ready_o = 1'b1;
    end
  end

  assign full_o = &valid_reg;

  // Response side: look up the original ID stored at the returned index.
  always_comb begin
    rsp_id_o = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (rsp_id_i == OutIdWidth'(i)) rsp_id_o = id_reg[i];
    end
  end

  // Table update: allocate, increment on push, decrement on pop, both cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= '0;
      for (int i = 0; i < MaxUniqIds; i++) begin
        id_reg[i]  <= '0;
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        if (push_vec[i] && !valid_reg[i]) begin
          valid_reg[i] <= 1'b1;
          id_reg[i]    <= req_id_i;
          cnt_reg[i]   <= CntWidth'(1);
        end else if (push_vec[i] && !pop_eff[i]) begin
          cnt_reg[i] <= cnt_reg[i] + CntWidth'(1);
        end else if (pop_eff[i] && !push_vec[i]) begin
          cnt_reg[i] <= cnt_reg[i] - CntWidth'(1);
          if (cnt_reg[i] == CntWidth'(1)) valid_reg[i] <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation-only sanity checks on pops and counter bounds.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!rsp_pop_i || |(pop_vec & valid_reg))
        else $error("floo_id_remapper: pop of invalid entry %0d", rsp_id_i);
      for (int i = 0; i < MaxUniqIds; i++) begin
        assert (cnt_reg[i] <= CntWidth'(MaxTxnsPerId))
          else $error("floo_id_remapper: counter overflow on entry %0d", i);
        assert (!valid_reg[i] || (cnt_reg[i] != '0))
          else $error("floo_id_remapper: counter underflow on entry %0d", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_floo_id_remapper.sv
// Directed bench for floo_id_remapper with the default 4-entry, 8-deep table.
module tb_floo_id_remapper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_id = 4'h0;
  logic       req_ready;
  logic [1:0] req_id_out;
  logic       rsp_pop = 1'b0;
  logic [1:0] rsp_id = 2'd0;
  logic [3:0] rsp_id_out;
  logic       full;

  int compared = 0;
  int mismatched = 0;

  floo_id_remapper #(
    .InIdWidth   (4),
    .MaxUniqIds  (4),
    .MaxTxnsPerId(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_id_i   (req_id),
    .req_ready_o(req_ready),
    .req_id_o   (req_id_out),
    .rsp_pop_i  (rsp_pop),
    .rsp_id_i   (rsp_id),
    .rsp_id_o   (rsp_id_out),
    .full_o     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rsp_pop   = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("in_reset_full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // One accepted or refused request: drive, check outputs, then clock it in.
  task automatic push_chk(input string tag, input logic [3:0] id, input logic exp_ready,
                          input logic [1:0] exp_idx);
    req_valid = 1'b1;
    req_id    = id;
    #1;
    $display("push id=0x%0h -> ready=%0d idx=%0d", id, req_ready, req_id_out);
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    check({tag, "_idx"}, 32'(req_id_out), 32'(exp_idx));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    req_valid = 1'b1;
    req_id    = 4'h0;
    rsp_id    = 2'd0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_idx", 32'(req_id_out), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rsp_id", 32'(rsp_id_out), 32'd0);
    req_valid = 1'b0;
    tick();

    // Basic allocation and reuse
    do_reset();
    push_chk("p34a", 4'h3, 1'b1, 2'd0);
    push_chk("p34b", 4'h5, 1'b1, 2'd1);
    push_chk("p34c", 4'h3, 1'b1, 2'd0);
    req_valid = 1'b0;
    rsp_id    = 2'd0;
    #1;
    check("p34_cnt0", 32'(dut.cnt_reg[0]), 32'd2);
    check("p34_cnt1", 32'(dut.cnt_reg[1]), 32'd1);
    check("p34_rsp0", 32'(rsp_id_out), 32'h3);
    rsp_id = 2'd1;
    #1 check("p34_rsp1", 32'(rsp_id_out), 32'h5);
    check("p34_full", 32'(full), 32'd0);

    // Per-ID counter saturation
    do_reset();
    for (int i = 0; i < 8; i++) push_chk("p35_fill", 4'hA, 1'b1, 2'd0);
    req_valid = 1'b1;
    req_id    = 4'hA;
    #1;
    check("p35_ninth_ready", 32'(req_ready), 32'd0);
    check("p35_ninth_idx", 32'(req_id_out), 32'd0);
    rsp_pop = 1'b1;
    rsp_id  = 2'd0;
    #1;
    check("p35_pop_ready", 32'(req_ready), 32'd0);
    check("p35_pop_rsp", 32'(rsp_id_out), 32'hA);
    tick();
    rsp_pop = 1'b0;
    #1;
    check("p35_after_ready", 32'(req_ready), 32'd1);
    check("p35_after_cnt", 32'(dut.cnt_reg[0]), 32'd7);
    tick();
    check("p35_refill_cnt", 32'(dut.cnt_reg[0]), 32'd8);
    check("p35_refill_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;

    // Full table
    do_reset();
    push_chk("p36a", 4'h1, 1'b1, 2'd0);
    push_chk("p36b", 4'h2, 1'b1, 2'd1);
    push_chk("p36c", 4'h3, 1'b1, 2'd2);
    push_chk("p36d", 4'h4, 1'b1, 2'd3);
    req_valid = 1'b0;
    #1 check("p36_full", 32'(full), 32'd1);
    push_chk("p36_nomatch", 4'h7, 1'b0, 2'd0);
    push_chk("p36_match", 4'h2, 1'b1, 2'd1);
    check("p36_cnt1", 32'(dut.cnt_reg[1]), 32'd2);

    // Freed entry only allocatable from the next cycle
    req_valid = 1'b1;
    req_id    = 4'h9;
    rsp_pop   = 1'b1;
    rsp_id    = 2'd2;
    #1;
    check("p37_same_ready", 32'(req_ready), 32'd0);
    check("p37_same_full", 32'(full), 32'd1);
    check("p37_same_rsp", 32'(rsp_id_out), 32'h3);
    tick();
    rsp_pop = 1'b0;
    #1;
    check("p37_next_full", 32'(full), 32'd0);
    check("p37_next_ready", 32'(req_ready), 32'd1);
    check("p37_next_idx", 32'(req_id_out), 32'd2);
    tick();
    req_valid = 1'b0;
    #1;
    check("p37_new_rsp", 32'(rsp_id_out), 32'h9);
    check("p37_refull", 32'(full), 32'd1);

    // Simultaneous push and pop of a single-count entry
    do_reset();
    push_chk("p38a", 4'h3, 1'b1, 2'd0);
    rsp_pop = 1'b1;
    rsp_id  = 2'd0;
    push_chk("p38_pushpop", 4'h3, 1'b1, 2'd0);
    rsp_pop   = 1'b0;
    req_valid = 1'b0;
    #1;
    check("p38_cnt", 32'(dut.cnt_reg[0]), 32'd1);
    check("p38_valid", 32'(dut.valid_reg[0]), 32'd1);
    check("p38_rsp", 32'(rsp_id_out), 32'h3);
    rsp_pop = 1'b1;
    tick();
    rsp_pop = 1'b0;
    #1 check("p38_freed", 32'(dut.valid_reg[0]), 32'd0);
    push_chk("p38_realloc", 4'h6, 1'b1, 2'd0);
    req_valid = 1'b0;

    // Asynchronous reset mid-operation
    do_reset();
    push_chk("p39a", 4'h1, 1'b1, 2'd0);
    push_chk("p39b", 4'h2, 1'b1, 2'd1);
    push_chk("p39c", 4'h3, 1'b1, 2'd2);
    req_valid = 1'b0;
    req_id    = 4'h2;
    #1 check("p39_pre_idx", 32'(req_id_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("p39_rst_full", 32'(full), 32'd0);
    check("p39_rst_idx", 32'(req_id_out), 32'd0);
    check("p39_rst_valid", 32'(dut.valid_reg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_chk("p39_push_f", 4'hF, 1'b1, 2'd0);
    req_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
